// File: rtl/rbot_pkg.sv
// rbot_pkg: shared move codes, batch geometry, sequencer state encoding and legality check
// Contents: MOVE_W/NUM_SLOTS geometry, MOVE_NONE and R..Di codes (2..13), seq_state_t, is_legal_move()
package rbot_pkg;
   localparam int MOVE_W    = 4;
   localparam int NUM_SLOTS = 15;
   localparam logic [MOVE_W-1:0] MOVE_NONE = 4'd0;
   localparam logic [MOVE_W-1:0] MOVE_R    = 4'd2;
   localparam logic [MOVE_W-1:0] MOVE_RI   = 4'd3;
   localparam logic [MOVE_W-1:0] MOVE_L    = 4'd4;
   localparam logic [MOVE_W-1:0] MOVE_LI   = 4'd5;
   localparam logic [MOVE_W-1:0] MOVE_F    = 4'd6;
   localparam logic [MOVE_W-1:0] MOVE_FI   = 4'd7;
   localparam logic [MOVE_W-1:0] MOVE_B    = 4'd8;
   localparam logic [MOVE_W-1:0] MOVE_BI   = 4'd9;
   localparam logic [MOVE_W-1:0] MOVE_U    = 4'd10;
   localparam logic [MOVE_W-1:0] MOVE_UI   = 4'd11;
   localparam logic [MOVE_W-1:0] MOVE_D    = 4'd12;
   localparam logic [MOVE_W-1:0] MOVE_DI   = 4'd13;
   typedef enum logic [2:0] {ST_IDLE, ST_SCAN, ST_ISSUE, ST_WAIT, ST_SETTLE, ST_DONE} seq_state_t;
   function automatic logic is_legal_move(input logic [MOVE_W-1:0] code);
      return code >= MOVE_R && code <= MOVE_DI;
   endfunction
endpackage

// File: rtl/move_sequencer_settle_timer.sv
// settle_timer: load/count/expire down-counter timing the mechanical settle after each move
// Ports: clock, reset_n (async, active low), load (restart a CYCLES-long interval),
//        en (count while settling), expired (interval elapsed / timer idle)
module settle_timer #(
   parameter int CYCLES = 1000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic load,
   input  logic en,
   output logic expired
);
   localparam int CW = CYCLES > 1 ? $clog2(CYCLES) : 1;
   // Loading CYCLES-1 and expiring at zero makes the settle state last exactly CYCLES clocks.
   localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES > 0 ? CYCLES - 1 : 0);
   logic [CW-1:0] cnt;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (load) cnt <= LOAD_VAL;
      else if (en && cnt != '0) cnt <= cnt - 1'b1;
   assign expired = cnt == '0;
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: unpacks buffered move batches and issues single moves to the motor controller
// Ports: clock, reset_n (async, active low); moves/new_moves (batch capture strobe);
//        move/move_valid/move_ready (issue handshake), move_done (move physically complete);
//        batch_done (1-cycle pulse), busy, overflow (sticky), bad_code (sticky);
//        total_moves (saturating completed-move count, only with MOVE_SEQUENCER_COUNT_EN defined)
module move_sequencer #(
   parameter int NUM_SLOTS     = rbot_pkg::NUM_SLOTS,
   parameter int MOVE_W        = rbot_pkg::MOVE_W,
   parameter int SETTLE_CYCLES = 1000
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [NUM_SLOTS*MOVE_W-1:0] moves,
   input  logic                        new_moves,
   output logic [MOVE_W-1:0]           move,
   output logic                        move_valid,
   input  logic                        move_ready,
   input  logic                        move_done,
   output logic                        batch_done,
   output logic                        busy,
   output logic                        overflow,
   output logic                        bad_code
`ifdef MOVE_SEQUENCER_COUNT_EN
   ,
   output logic [15:0]                 total_moves
`endif
);
   import rbot_pkg::*;
   localparam int BW = NUM_SLOTS * MOVE_W;
   localparam int CW = $clog2(NUM_SLOTS + 1);
   seq_state_t state;
   logic [BW-1:0] pend, active;
   logic pend_full, transfer, expired;
   logic [CW-1:0] cnt;
   logic [MOVE_W-1:0] top;
   assign top      = active[BW-1 -: MOVE_W];
   assign transfer = state == ST_IDLE && pend_full;
   assign busy     = state != ST_IDLE || pend_full;
   settle_timer #(.CYCLES(SETTLE_CYCLES)) u_settle (
      .clock  (clock),
      .reset_n(reset_n),
      .load   (state == ST_WAIT && move_done),
      .en     (state == ST_SETTLE),
      .expired(expired)
   );
   // A strobe is only dropped when pending stays occupied; a transfer in the same cycle frees it.
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         pend      <= '0;
         pend_full <= 1'b0;
         overflow  <= 1'b0;
      end else if (new_moves && pend_full && !transfer) overflow <= 1'b1;
      else if (new_moves) begin
         pend      <= moves;
         pend_full <= 1'b1;
      end else if (transfer) pend_full <= 1'b0;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state      <= ST_IDLE;
         active     <= '0;
         cnt        <= '0;
         move       <= '0;
         move_valid <= 1'b0;
         batch_done <= 1'b0;
         bad_code   <= 1'b0;
      end else begin
         batch_done <= 1'b0;
         case (state)
            ST_IDLE: if (pend_full) begin
               active <= pend;
               cnt    <= CW'(NUM_SLOTS);
               state  <= ST_SCAN;
            end
            ST_SCAN: if (is_legal_move(top)) begin
               move       <= top;
               move_valid <= 1'b1;
               state      <= ST_ISSUE;
            end else begin
               if (top != '0) bad_code <= 1'b1;
               active <= active << MOVE_W;
               cnt    <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state      <= ST_DONE;
                  batch_done <= 1'b1;
               end
            end
            ST_ISSUE: if (move_ready) begin
               move       <= '0;
               move_valid <= 1'b0;
               state      <= ST_WAIT;
            end
            // With no settle the last completion goes straight to DONE, since SCAN assumes slots remain.
            ST_WAIT: if (move_done) begin
               active     <= active << MOVE_W;
               cnt        <= cnt - 1'b1;
               state      <= SETTLE_CYCLES > 0 ? ST_SETTLE : (cnt == CW'(1) ? ST_DONE : ST_SCAN);
               batch_done <= SETTLE_CYCLES == 0 && cnt == CW'(1);
            end
            ST_SETTLE: if (expired) begin
               state      <= cnt == '0 ? ST_DONE : ST_SCAN;
               batch_done <= cnt == '0;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
`ifdef MOVE_SEQUENCER_COUNT_EN
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) total_moves <= '0;
      else if (state == ST_WAIT && move_done && total_moves != 16'hFFFF) total_moves <= total_moves + 16'd1;
`endif
endmodule
